// File: rtl/tiny_dnn_pkg.sv
// -----------------------------------------------------------------------------
// tiny_dnn_pkg
//   Types shared by the tiny-dnn operand buffers. Widths are deliberately not
//   defined here; every block sizes itself from its own parameters.
// -----------------------------------------------------------------------------
package tiny_dnn_pkg;

  // Ownership of one buffer side.
  //   FREE   : host may fill it
  //   LOADED : fill complete, waiting for the engine to claim it
  //   ACTIVE : engine owns it and may read it
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    LOADED = 2'd1,
    ACTIVE = 2'd2
  } side_state_t;

endpackage

// File: rtl/src_buf_pp_if.sv
// -----------------------------------------------------------------------------
// src_buf_pp_if
//   Host write channel and engine read channel of the ping-pong source buffer.
//   master : host/engine side (drives beats, handshakes, read strobes)
//   slave  : the buffer itself
//
//   src_v/src_a/src_d/src_last  write beat (LANES words per beat)
//   src_rdy                      current write side is FREE
//   ovf                          sticky: beat presented while src_rdy low
//   run_rdy/run_start/run_done   claim/release of the read side
//   exec/ia                      read strobe and word index
//   d/d_v                        read data, valid one cycle after exec
// -----------------------------------------------------------------------------
interface src_buf_pp_if #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int DEPTH = 1024
);
  localparam int LW  = $clog2(LANES);
  localparam int RA  = $clog2(DEPTH);
  localparam int IAW = RA + LW;

  logic                  src_v;
  logic [RA-1:0]         src_a;
  logic [LANES*DW-1:0]   src_d;
  logic                  src_last;
  logic                  src_rdy;
  logic                  ovf;
  logic                  run_rdy;
  logic                  run_start;
  logic                  run_done;
  logic                  exec;
  logic [IAW-1:0]        ia;
  logic [DW-1:0]         d;
  logic                  d_v;

  modport master (
    output src_v, src_a, src_d, src_last, run_start, run_done, exec, ia,
    input  src_rdy, ovf, run_rdy, d, d_v
  );

  modport slave (
    input  src_v, src_a, src_d, src_last, run_start, run_done, exec, ia,
    output src_rdy, ovf, run_rdy, d, d_v
  );

endinterface

// File: rtl/src_buf_pp_bank.sv
// -----------------------------------------------------------------------------
// src_bank
//   DEPTH x DW simple dual-port RAM, one write port and one read port.
//   clk      clock
//   we/wa/wd write enable, address, data
//   re/ra    read enable, address
//   rd       registered read data; holds its value while re is low
//   Data storage and rd are not reset.
// -----------------------------------------------------------------------------
module src_bank #(
  parameter int DW    = 16,
  parameter int DEPTH = 1024,
  localparam int RA   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [RA-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [RA-1:0] ra,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  // Holding rd when idle is what lets the top keep d stable between reads
  // without a separate output data register.
  always_ff @(posedge clk) begin
    if (re) begin
      rd <= mem[ra];
    end
  end

endmodule

// File: rtl/src_buf_pp.sv
// -----------------------------------------------------------------------------
// src_buf_pp
//   Ping-pong source buffer for the MAC datapath. The host fills one side a
//   full LANES-word beat at a time while the engine reads single words from
//   the other side. Side ownership moves FREE -> LOADED -> ACTIVE -> FREE via
//   src_last, run_start and run_done.
//
//   clk    clock, all logic on posedge
//   reset  synchronous, active-high; both sides return to FREE
//   bus    src_buf_pp_if.slave (write channel, claim/release, read channel)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   FREE    | side empty or released; host may write it when it is wsel
//   LOADED  | fill finished (src_last accepted); waiting for run_start
//   ACTIVE  | claimed by the engine; exec reads allowed; run_done frees it
// -----------------------------------------------------------------------------
module src_buf_pp
  import tiny_dnn_pkg::*;
#(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int DEPTH = 1024
) (
  input logic         clk,
  input logic         reset,
  src_buf_pp_if.slave bus
);

  localparam int LW  = $clog2(LANES);
  localparam int RA  = $clog2(DEPTH);
  localparam int IAW = RA + LW;

  side_state_t   state_q [2];
  side_state_t   state_n [2];
  logic          wsel_q, wsel_n;
  logic          rsel_q, rsel_n;
  logic          ovf_q, ovf_n;

  logic          src_rdy;
  logic          run_rdy;
  logic          rd_side_active;
  logic          wr_acc;
  logic          rd_acc;

  logic [LW-1:0] rd_lane;
  logic [RA-1:0] rd_row;

  logic          dv_q;
  logic          d_seen_q;
  logic          dsel_side_q;
  logic [LW-1:0] dsel_lane_q;

  logic [DW-1:0] rd_data [2][LANES];

  // ---------------------------------------------------------------------------
  // Status decode (from registered state only)
  // ---------------------------------------------------------------------------
  assign src_rdy        = (state_q[wsel_q] == FREE);
  assign run_rdy        = (state_q[rsel_q] == LOADED);
  assign rd_side_active = (state_q[rsel_q] == ACTIVE);

  assign wr_acc  = bus.src_v && src_rdy;
  assign rd_acc  = bus.exec && rd_side_active;

  assign rd_lane = bus.ia[LW-1:0];
  assign rd_row  = bus.ia[IAW-1:LW];

  // ---------------------------------------------------------------------------
  // Side ownership state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q[0] <= FREE;
      state_q[1] <= FREE;
      wsel_q     <= 1'b0;
      rsel_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q[0] <= state_n[0];
      state_q[1] <= state_n[1];
      wsel_q     <= wsel_n;
      rsel_q     <= rsel_n;
      ovf_q      <= ovf_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A write completion and a claim/release can land in the
  // same cycle; they always target different sides because a write needs
  // FREE while claim needs LOADED and release needs ACTIVE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n[0] = state_q[0];
    state_n[1] = state_q[1];
    wsel_n     = wsel_q;
    rsel_n     = rsel_q;
    ovf_n      = ovf_q | (bus.src_v & ~src_rdy);

    if (wr_acc && bus.src_last) begin
      state_n[wsel_q] = LOADED;
      wsel_n          = ~wsel_q;
    end

    if (bus.run_start && run_rdy) begin
      state_n[rsel_q] = ACTIVE;
    end else if (bus.run_done && rd_side_active) begin
      // A same-cycle exec still reads this side: the read uses rsel_q.
      state_n[rsel_q] = FREE;
      rsel_n          = ~rsel_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Bank array: 2 sides x LANES banks. Each write beat hits every bank of the
  // write side; a read enables exactly one bank.
  // ---------------------------------------------------------------------------
  for (genvar s = 0; s < 2; s++) begin : g_side
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic bank_we;
      logic bank_re;

      assign bank_we = wr_acc && (wsel_q == 1'(s));
      assign bank_re = rd_acc && (rsel_q == 1'(s)) && (rd_lane == LW'(k));

      src_bank #(
        .DW    (DW),
        .DEPTH (DEPTH)
      ) u_bank (
        .clk (clk),
        .we  (bank_we),
        .wa  (bus.src_a),
        .wd  (bus.src_d[k*DW +: DW]),
        .re  (bank_re),
        .ra  (rd_row),
        .rd  (rd_data[s][k])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // Read output. The bank chosen by the last accepted exec is remembered so
  // that d keeps showing that word until the next accepted exec, even after
  // the side is released. d_seen_q forces d to zero after reset because the
  // bank read registers themselves are not reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      dv_q        <= 1'b0;
      d_seen_q    <= 1'b0;
      dsel_side_q <= 1'b0;
      dsel_lane_q <= '0;
    end else begin
      dv_q <= rd_acc;
      if (rd_acc) begin
        d_seen_q    <= 1'b1;
        dsel_side_q <= rsel_q;
        dsel_lane_q <= rd_lane;
      end
    end
  end

  assign bus.d       = d_seen_q ? rd_data[dsel_side_q][dsel_lane_q] : '0;
  assign bus.d_v     = dv_q;
  assign bus.src_rdy = src_rdy;
  assign bus.run_rdy = run_rdy;
  assign bus.ovf     = ovf_q;

  // Only the read side can ever be ACTIVE.
  a_active_is_rsel : assert property (
    @(posedge clk) disable iff (reset) state_q[~rsel_q] != ACTIVE
  );

endmodule

// File: tb/tb_src_buf_pp.sv
module tb_src_buf_pp;

  localparam int DW    = 16;
  localparam int LANES = 4;
  localparam int DEPTH = 1024;
  localparam int NW    = LANES * DEPTH;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  src_buf_pp_if #(.DW(DW), .LANES(LANES), .DEPTH(DEPTH)) bus ();
  src_buf_pp_if #(.DW(16), .LANES(8), .DEPTH(256))       bus8 ();

  src_buf_pp #(.DW(DW), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  src_buf_pp #(.DW(16), .LANES(8), .DEPTH(256)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each side is a flat word array indexed by ia.
  // Side state: 0 = free, 1 = loaded, 2 = active.
  // ---------------------------------------------------------------------------
  int          st [2];
  int          ws, rs;
  bit          m_ovf, m_dv, m_dk;
  logic [15:0] m_d;
  logic [15:0] mem [2][NW];
  bit          vld [2][NW];

  function automatic logic [63:0] pack4(input logic [15:0] base, input int row);
    logic [63:0] p;
    for (int k = 0; k < 4; k++) p[k*16 +: 16] = base + 16'(4*row + k);
    return p;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_src_rdy"}, bus.src_rdy, st[ws] == 0);
    chk({tag, "_run_rdy"}, bus.run_rdy, st[rs] == 1);
    chk({tag, "_ovf"},     bus.ovf,     m_ovf);
    chk({tag, "_d_v"},     bus.d_v,     m_dv);
    if (m_dk) chk({tag, "_d"}, bus.d, m_d);
  endtask

  task automatic step(input string tag, input bit v, input int a, input logic [63:0] data,
                      input bit last, input bit start, input bit done,
                      input bit ex, input int ia_i);
    bit wrdy, ract, rld;
    bus.src_v     = v;
    bus.src_a     = a[9:0];
    bus.src_d     = data;
    bus.src_last  = last;
    bus.run_start = start;
    bus.run_done  = done;
    bus.exec      = ex;
    bus.ia        = ia_i[11:0];

    wrdy = (st[ws] == 0);
    ract = (st[rs] == 2);
    rld  = (st[rs] == 1);

    if (ex && ract) begin
      m_dv = 1'b1;
      m_d  = mem[rs][ia_i];
      m_dk = vld[rs][ia_i];
    end else begin
      m_dv = 1'b0;
    end

    if (v && wrdy) begin
      for (int k = 0; k < LANES; k++) begin
        mem[ws][a*LANES + k] = data[k*16 +: 16];
        vld[ws][a*LANES + k] = 1'b1;
      end
      if (last) begin
        st[ws] = 1;
        ws     = ws ^ 1;
      end
    end else if (v) begin
      m_ovf = 1'b1;
    end

    if (start && rld) st[rs] = 2;
    else if (done && ract) begin
      st[rs] = 0;
      rs     = rs ^ 1;
    end

    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    bus.src_v = 0; bus.src_a = '0; bus.src_d = '0; bus.src_last = 0;
    bus.run_start = 0; bus.run_done = 0; bus.exec = 0; bus.ia = '0;
    bus8.src_v = 0; bus8.src_a = '0; bus8.src_d = '0; bus8.src_last = 0;
    bus8.run_start = 0; bus8.run_done = 0; bus8.exec = 0; bus8.ia = '0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    st[0] = 0; st[1] = 0; ws = 0; rs = 0;
    m_ovf = 0; m_dv = 0; m_d = '0; m_dk = 1;
    check_outputs(tag);
    chk({tag, "_d_zero"}, bus.d, 16'h0000);
    chk({tag, "_src_rdy1"}, bus.src_rdy, 1'b1);
  endtask

  initial begin
    logic [127:0] d8;
    int row, lane;

    reset = 1'b1;
    idle_inputs();
    do_reset("rst0");

    // ---------------- LANES=8, DEPTH=256 instance: basic fill/read ----------
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) d8[k*16 +: 16] = 16'h1000 + 16'(8*r + k);
      bus8.src_v = 1; bus8.src_a = 8'(r); bus8.src_d = d8; bus8.src_last = (r == 3);
      @(posedge clk); #1;
    end
    bus8.src_v = 0; bus8.src_last = 0;
    chk("l8_run_rdy", bus8.run_rdy, 1'b1);
    chk("l8_src_rdy", bus8.src_rdy, 1'b1);
    bus8.run_start = 1; @(posedge clk); #1; bus8.run_start = 0;
    chk("l8_claimed", bus8.run_rdy, 1'b0);
    for (int i = 0; i < 32; i++) begin
      bus8.exec = 1; bus8.ia = 11'(i);
      @(posedge clk); #1;
      chk("l8_d", bus8.d, 16'h1000 + 16'(i));
      chk("l8_d_v", bus8.d_v, 1'b1);
    end
    bus8.exec = 0; @(posedge clk); #1;
    chk("l8_d_v_idle", bus8.d_v, 1'b0);
    chk("l8_d_hold", bus8.d, 16'h101F);

    // ---------------- run_start / exec while FREE are ignored ---------------
    step("free_start", 0, 0, 0, 0, 1, 0, 0, 0);
    chk("free_start_ign", bus.run_rdy, 1'b0);
    step("free_exec", 0, 0, 0, 0, 0, 0, 1, 0);
    chk("free_exec_dv", bus.d_v, 1'b0);

    // ---------------- fill S0, claim, read ----------------------------------
    for (int r = 0; r < 4; r++) step("s0_fill", 1, r, pack4(16'h1000, r), r == 3, 0, 0, 0, 0);
    chk("s0_loaded", bus.run_rdy, 1'b1);
    step("s0_start", 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step("s0_rd", 0, 0, 0, 0, 0, 0, 1, i);
      chk("s0_d", bus.d, 16'h1000 + 16'(i));
      chk("s0_dv", bus.d_v, 1'b1);
    end
    step("s0_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("s0_idle_dv", bus.d_v, 1'b0);

    // ---------------- overlap: fill S1 while reading S0 ---------------------
    for (int r = 0; r < 4; r++) begin
      step("ovl_fill", 1, r, pack4(16'h2000, r), r == 3, 0, 0, 1, 4*r + 1);
      if (r < 3) chk("ovl_src_rdy", bus.src_rdy, 1'b1);
    end
    chk("ovl_full", bus.src_rdy, 1'b0);
    step("s0_done", 0, 0, 0, 0, 0, 1, 0, 0);
    chk("s0_done_src_rdy", bus.src_rdy, 1'b1);
    chk("s0_done_run_rdy", bus.run_rdy, 1'b1);
    step("s1_start", 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step("s1_rd", 0, 0, 0, 0, 0, 0, 1, i);
      chk("s1_d", bus.d, 16'h2000 + 16'(i));
    end

    // ---------------- exec and run_done in the same cycle -------------------
    step("ex_done", 0, 0, 0, 0, 0, 1, 1, 5);
    chk("ex_done_d", bus.d, 16'h2005);
    chk("ex_done_dv", bus.d_v, 1'b1);
    chk("ex_done_free", bus.run_rdy, 1'b0);
    step("after_done", 0, 0, 0, 0, 0, 0, 1, 6);
    chk("after_done_dv", bus.d_v, 1'b0);

    // ---------------- overflow with both sides loaded -----------------------
    step("top_row", 1, DEPTH-1, pack4(16'h3F00, 0), 0, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) step("ov_fill0", 1, r, pack4(16'h3000, r), r == 3, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) step("ov_fill1", 1, r, pack4(16'h4000, r), r == 3, 0, 0, 0, 0);
    chk("both_loaded", bus.src_rdy, 1'b0);
    step("ovf_beat", 1, 0, 64'hDEAD_DEAD_DEAD_DEAD, 1, 0, 0, 0, 0);
    chk("ovf_set", bus.ovf, 1'b1);
    step("ld_exec", 0, 0, 0, 0, 0, 0, 1, 2);
    chk("ld_exec_dv", bus.d_v, 1'b0);
    chk("ld_exec_hold", bus.d, 16'h2005);
    step("ov_start0", 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step("ov_rd0", 0, 0, 0, 0, 0, 0, 1, i);
      chk("ov_d0", bus.d, 16'h3000 + 16'(i));
    end
    step("top_rd", 0, 0, 0, 0, 0, 0, 1, 4*(DEPTH-1) + 3);
    chk("top_rd_d", bus.d, 16'h3F03);
    step("ov_done0", 0, 0, 0, 0, 0, 1, 0, 0);
    step("ov_start1", 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step("ov_rd1", 0, 0, 0, 0, 0, 0, 1, i);
      chk("ov_d1", bus.d, 16'h4000 + 16'(i));
    end

    // ---------------- reset mid-run -----------------------------------------
    step("pre_rst", 0, 0, 0, 0, 0, 0, 1, 1);
    do_reset("mid_rst");
    chk("mid_rst_ovf", bus.ovf, 1'b0);
    chk("mid_rst_run_rdy", bus.run_rdy, 1'b0);

    // ---------------- randomized traffic ------------------------------------
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rnd_rst");
      end else begin
        row  = ($urandom_range(0, 9) == 0) ? DEPTH-1 : int'($urandom_range(0, 3));
        lane = int'($urandom_range(0, LANES-1));
        step("rnd",
             $urandom_range(0, 1) == 1,
             ($urandom_range(0, 9) == 0) ? DEPTH-1 : int'($urandom_range(0, 3)),
             {$urandom, $urandom},
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 4) < 3,
             row*LANES + lane);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
